// File: rtl/alu64bit_arbiter.sv
// Round-robin sequencer that shares one combinational ALU among NREQ requesters,
// holding operands for SETTLE_CYCLES clocks and returning the result tagged with its id.
module alu64bit_arbiter #(
  parameter int NREQ          = 4,
  parameter int WIDTH         = 64,
  parameter int SETTLE_CYCLES = 2,
  parameter int IDW           = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_cin,
  input  logic [NREQ*2-1:0]     req_op,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic                  alu_cin,
  output logic [1:0]            alu_op,
  input  logic [WIDTH-1:0]      alu_s,
  input  logic                  alu_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_s,
  output logic                  rsp_cout,
  output logic [IDW-1:0]        rsp_id,
  output logic                  busy,
  output logic [1:0]            dbg_state
);

  // Valid/ready: a transfer happens on a rising edge where both are high. A requester
  // holds valid and payload until it sees ready; the response is held until rsp_ready.
  localparam int CNTW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW   = IDW + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [IDW-1:0]   last_grant_q, last_grant_d;
  logic [IDW-1:0]   id_q, id_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             cin_q, cin_d;
  logic [1:0]       op_q, op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_s_q, rsp_s_d;
  logic             rsp_cout_q, rsp_cout_d;
  logic             busy_q, busy_d;

  logic             win_found;
  logic [IDW-1:0]   win_idx;
  logic [CW-1:0]    cand;

  // Scan upward from the requester after the last grant, wrapping at NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, last_grant_q} + CW'(k);
      if (cand >= CW'(NREQ)) cand = cand - CW'(NREQ);
      if (!win_found && req_valid[cand[IDW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[IDW-1:0];
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    cnt_d        = cnt_q;
    a_d          = a_q;
    b_d          = b_q;
    cin_d        = cin_q;
    op_d         = op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_s_d      = rsp_s_q;
    rsp_cout_d   = rsp_cout_q;
    req_ready    = '0;
    unique case (state_q)
      S_IDLE: begin
        if (win_found && !rst) begin
          req_ready[win_idx] = 1'b1;
          a_d          = req_a[win_idx*WIDTH +: WIDTH];
          b_d          = req_b[win_idx*WIDTH +: WIDTH];
          cin_d        = req_cin[win_idx];
          op_d         = req_op[win_idx*2 +: 2];
          id_d         = win_idx;
          last_grant_d = win_idx;
          cnt_d        = CNTW'(SETTLE_CYCLES);
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        cnt_d = cnt_q - CNTW'(1);
        if (cnt_q == CNTW'(1)) begin
          rsp_s_d     = alu_s;
          rsp_cout_d  = alu_cout;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      last_grant_q <= IDW'(NREQ - 1);
      id_q         <= '0;
      cnt_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cin_q        <= 1'b0;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_s_q      <= '0;
      rsp_cout_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      cnt_q        <= cnt_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cin_q        <= cin_d;
      op_q         <= op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_s_q      <= rsp_s_d;
      rsp_cout_q   <= rsp_cout_d;
      busy_q       <= busy_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_cin   = cin_q;
  assign alu_op    = op_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_s     = rsp_s_q;
  assign rsp_cout  = rsp_cout_q;
  assign rsp_id    = id_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu64bit_arbiter.sv
// Bench for alu64bit_arbiter with an adder ALU stub, a round-robin reference model
// and a result scoreboard.
`timescale 1ns/1ps
module tb_alu64bit_arbiter;

  localparam int NREQ   = 4;
  localparam int WIDTH  = 64;
  localparam int SETTLE = 2;
  localparam int IDW    = $clog2(NREQ);
  localparam int EW     = IDW + 1 + WIDTH;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a, req_b;
  logic [NREQ-1:0]       req_cin;
  logic [NREQ*2-1:0]     req_op;
  logic [WIDTH-1:0]      alu_a, alu_b, alu_s;
  logic                  alu_cin, alu_cout;
  logic [1:0]            alu_op;
  logic                  rsp_valid, rsp_ready;
  logic [WIDTH-1:0]      rsp_s;
  logic                  rsp_cout;
  logic [IDW-1:0]        rsp_id;
  logic                  busy;
  logic [1:0]            dbg_state;

  logic [WIDTH-1:0] op_a [NREQ];
  logic [WIDTH-1:0] op_b [NREQ];
  logic             op_cin [NREQ];
  logic [1:0]       op_op [NREQ];

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int model_last;

  for (genvar g = 0; g < NREQ; g++) begin : g_pack
    assign req_a[g*WIDTH +: WIDTH] = op_a[g];
    assign req_b[g*WIDTH +: WIDTH] = op_b[g];
    assign req_cin[g]              = op_cin[g];
    assign req_op[g*2 +: 2]        = op_op[g];
  end

  logic [WIDTH:0] alu_sum;
  assign alu_sum  = {1'b0, alu_a} + {1'b0, alu_b} + {{WIDTH{1'b0}}, alu_cin};
  assign alu_s    = alu_sum[WIDTH-1:0];
  assign alu_cout = alu_sum[WIDTH];

  alu64bit_arbiter #(
    .NREQ(NREQ), .WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE), .IDW(IDW)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_op(req_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_op(alu_op),
    .alu_s(alu_s), .alu_cout(alu_cout),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_s(rsp_s), .rsp_cout(rsp_cout), .rsp_id(rsp_id),
    .busy(busy), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic int model_pick(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      if (v[(model_last + k) % NREQ]) return (model_last + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int w);
    logic [NREQ-1:0] r;
    r = '0;
    if (w >= 0) r[w] = 1'b1;
    return r;
  endfunction

  function automatic logic [EW-1:0] model_result(input int w);
    logic [WIDTH:0] sum;
    sum = {1'b0, op_a[w]} + {1'b0, op_b[w]} + (WIDTH+1)'(op_cin[w]);
    return {IDW'(w), sum};
  endfunction

  task automatic rand_ops(input int i);
    op_a[i]   = {$urandom, $urandom};
    op_b[i]   = {$urandom, $urandom};
    if ($urandom_range(0, 7) == 0) op_a[i] = '1;
    op_cin[i] = 1'($urandom_range(0, 1));
    op_op[i]  = 2'($urandom_range(0, 3));
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++; if (req_ready !== '0) begin bad++; $display("FAIL rst_ready: got %b want 0", req_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_rsp_valid: got %b want 0", rsp_valid); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
      total++; if (alu_a !== '0) begin bad++; $display("FAIL rst_alu_a: got %h want 0", alu_a); end
    end
    rst = 1'b0;
    model_last = NREQ - 1;
    #1;
    total++; if (req_ready !== onehot(0)) begin bad++; $display("FAIL rst_first_grant: got %b want %b", req_ready, onehot(0)); end
    req_valid = '0;
    @(negedge clk);
    total++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rst_idle: got busy=%b rsp_valid=%b want 0 0", busy, rsp_valid); end
  endtask

  task automatic test_single();
    op_a[2] = '1; op_b[2] = '0; op_cin[2] = 1'b1; op_op[2] = 2'b11;
    rsp_ready = 1'b1;
    req_valid = onehot(2);
    #1;
    total++; if (req_ready !== onehot(2)) begin bad++; $display("FAIL single_grant: got %b want %b", req_ready, onehot(2)); end
    @(negedge clk);
    req_valid = '0;
    total++; if (alu_op !== 2'b11 || alu_a !== {WIDTH{1'b1}}) begin bad++; $display("FAIL single_alu_in: got op=%b a=%h", alu_op, alu_a); end
    total++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL single_exec1: got busy=%b rsp_valid=%b want 1 0", busy, rsp_valid); end
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_exec2: got rsp_valid=%b want 0", rsp_valid); end
    @(negedge clk);
    total++;
    if (rsp_valid !== 1'b1 || rsp_s !== '0 || rsp_cout !== 1'b1 || rsp_id !== IDW'(2)) begin
      bad++; $display("FAIL single_rsp: got v=%b s=%h c=%b id=%0d want 1 0 1 2", rsp_valid, rsp_s, rsp_cout, rsp_id);
    end
    model_last = 2;
    @(negedge clk);
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL single_taken: got rsp_valid=%b want 0", rsp_valid); end
  endtask

  task automatic test_round_robin();
    int accepts, cyc, last_acc, renew, w;
    bit inflight, release_next;
    logic [NREQ-1:0] exp_rdy;
    logic [EW-1:0] exp;
    @(negedge clk);
    rst = 1'b1; req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    model_last = NREQ - 1;
    for (int i = 0; i < NREQ; i++) rand_ops(i);
    req_valid = '1; rsp_ready = 1'b1;
    accepts = 0; cyc = 0; last_acc = -1; renew = -1; inflight = 0; release_next = 0;
    while ((accepts < 5 || inflight) && cyc < 100) begin
      if (release_next) begin inflight = 0; release_next = 0; end
      if (renew >= 0) begin rand_ops(renew); renew = -1; end
      if (accepts >= 5) req_valid = '0;
      #1;
      if (rsp_valid && rsp_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rr_rsp: got unexpected response id=%0d want none", rsp_id);
        end else begin
          exp = exp_q.pop_front();
          if ({rsp_id, rsp_cout, rsp_s} !== exp) begin bad++; $display("FAIL rr_rsp: got %h want %h", {rsp_id, rsp_cout, rsp_s}, exp); end
        end
        release_next = 1;
      end
      w = inflight ? -1 : model_pick(req_valid);
      exp_rdy = onehot(w);
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rr_grant: got %b want %b", req_ready, exp_rdy); end
      if (w >= 0) begin
        exp_q.push_back(model_result(w));
        if (last_acc >= 0) begin
          total++; if (cyc - last_acc != SETTLE + 2) begin bad++; $display("FAIL rr_spacing: got %0d want %0d", cyc - last_acc, SETTLE + 2); end
        end
        last_acc = cyc; model_last = w; inflight = 1; renew = w; accepts++;
      end
      @(negedge clk);
      cyc++;
    end
    total++; if (accepts < 5 || inflight) begin bad++; $display("FAIL rr_timeout: got accepts=%0d want 5", accepts); end
  endtask

  task automatic test_backpressure();
    int i, w, got;
    logic [NREQ-1:0] exp_rdy;
    logic [EW-1:0] exp, exp2;
    rsp_ready = 1'b0;
    i = $urandom_range(0, NREQ - 1);
    rand_ops(i);
    req_valid = onehot(i);
    #1;
    w = model_pick(req_valid);
    exp_rdy = onehot(w);
    total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL bp_grant: got %b want %b", req_ready, exp_rdy); end
    exp = model_result(w); model_last = w;
    @(negedge clk);
    for (int k = 0; k < NREQ; k++) rand_ops(k);
    req_valid = '1;
    @(negedge clk);
    @(negedge clk);
    total++; if (rsp_valid !== 1'b1 || {rsp_id, rsp_cout, rsp_s} !== exp) begin bad++; $display("FAIL bp_rsp: got v=%b %h want 1 %h", rsp_valid, {rsp_id, rsp_cout, rsp_s}, exp); end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b1 || {rsp_id, rsp_cout, rsp_s} !== exp) begin bad++; $display("FAIL bp_hold: got v=%b %h want 1 %h", rsp_valid, {rsp_id, rsp_cout, rsp_s}, exp); end
      total++; if (req_ready !== '0) begin bad++; $display("FAIL bp_ready: got %b want 0", req_ready); end
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release: got rsp_valid=%b want 0", rsp_valid); end
    w = model_pick(req_valid);
    exp_rdy = onehot(w);
    total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL bp_next_grant: got %b want %b", req_ready, exp_rdy); end
    exp2 = model_result(w); model_last = w;
    @(negedge clk);
    req_valid = '0; rsp_ready = 1'b1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL bp_busy: got %b want 1", busy); end
    got = 0;
    for (int c = 0; c < 8 && got == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        total++; if ({rsp_id, rsp_cout, rsp_s} !== exp2) begin bad++; $display("FAIL bp_rsp2: got %h want %h", {rsp_id, rsp_cout, rsp_s}, exp2); end
      end
    end
    total++; if (got == 0) begin bad++; $display("FAIL bp_timeout: got no response want one"); end
    @(negedge clk);
  endtask

  task automatic test_wrap_around();
    int w, got;
    logic [NREQ-1:0] exp_rdy;
    logic [EW-1:0] exp;
    rst = 1'b1; req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    model_last = NREQ - 1;
    rand_ops(1); rand_ops(3);
    req_valid = 4'b1010; rsp_ready = 1'b1;
    #1;
    w = model_pick(req_valid); exp_rdy = onehot(w);
    total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL wrap_first: got %b want %b", req_ready, exp_rdy); end
    exp = model_result(w); model_last = w;
    @(negedge clk);
    req_valid[w] = 1'b0;
    got = 0;
    for (int c = 0; c < 8 && got == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        total++; if ({rsp_id, rsp_cout, rsp_s} !== exp) begin bad++; $display("FAIL wrap_rsp1: got %h want %h", {rsp_id, rsp_cout, rsp_s}, exp); end
      end
    end
    total++; if (got == 0) begin bad++; $display("FAIL wrap_timeout1: got no response want one"); end
    @(negedge clk);
    #1;
    w = model_pick(req_valid); exp_rdy = onehot(w);
    total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL wrap_second: got %b want %b", req_ready, exp_rdy); end
    exp = model_result(w); model_last = w;
    @(negedge clk);
    req_valid = '0;
    got = 0;
    for (int c = 0; c < 8 && got == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        total++; if ({rsp_id, rsp_cout, rsp_s} !== exp) begin bad++; $display("FAIL wrap_rsp2: got %h want %h", {rsp_id, rsp_cout, rsp_s}, exp); end
      end
    end
    total++; if (got == 0) begin bad++; $display("FAIL wrap_timeout2: got no response want one"); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_exec();
    int w, got;
    logic [NREQ-1:0] exp_rdy;
    logic [EW-1:0] exp;
    rsp_ready = 1'b1;
    rand_ops(2);
    req_valid = onehot(2);
    #1;
    w = model_pick(req_valid); exp_rdy = onehot(w);
    total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rme_grant: got %b want %b", req_ready, exp_rdy); end
    @(negedge clk);
    req_valid = '0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_last = NREQ - 1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || alu_a !== '0 || req_ready !== '0) begin
      bad++; $display("FAIL rme_cleared: got v=%b busy=%b a=%h rdy=%b want all 0", rsp_valid, busy, alu_a, req_ready);
    end
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rme_ghost: got rsp_valid=%b want 0", rsp_valid); end
    end
    rand_ops(1); rand_ops(2); rand_ops(3);
    req_valid = 4'b1110;
    #1;
    w = model_pick(req_valid); exp_rdy = onehot(w);
    total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rme_next_grant: got %b want %b", req_ready, exp_rdy); end
    exp = model_result(w); model_last = w;
    @(negedge clk);
    req_valid = '0;
    got = 0;
    for (int c = 0; c < 8 && got == 0; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        got = 1;
        total++; if ({rsp_id, rsp_cout, rsp_s} !== exp) begin bad++; $display("FAIL rme_rsp: got %h want %h", {rsp_id, rsp_cout, rsp_s}, exp); end
      end
    end
    total++; if (got == 0) begin bad++; $display("FAIL rme_timeout: got no response want one"); end
    @(negedge clk);
  endtask

  task automatic test_random();
    int accepts, cyc, renew, w;
    bit inflight, release_next;
    logic [NREQ-1:0] exp_rdy;
    logic [EW-1:0] exp;
    accepts = 0; cyc = 0; renew = -1; inflight = 0; release_next = 0;
    while ((accepts < 40 || inflight || req_valid != '0) && cyc < 3000) begin
      if (release_next) begin inflight = 0; release_next = 0; end
      if (renew >= 0) begin
        total++;
        if ({alu_op, alu_cin, alu_a, alu_b} !== {op_op[renew], op_cin[renew], op_a[renew], op_b[renew]}) begin
          bad++; $display("FAIL rnd_alu_in: got op=%b cin=%b a=%h b=%h want op=%b cin=%b a=%h b=%h", alu_op, alu_cin, alu_a, alu_b,
                          op_op[renew], op_cin[renew], op_a[renew], op_b[renew]);
        end
        req_valid[renew] = 1'b0;
        renew = -1;
      end
      if (accepts < 40) begin
        for (int k = 0; k < NREQ; k++) begin
          if (!req_valid[k] && $urandom_range(0, 3) == 0) begin
            rand_ops(k);
            req_valid[k] = 1'b1;
          end
        end
      end
      rsp_ready = ($urandom_range(0, 2) != 0);
      #1;
      if (rsp_valid && rsp_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++; $display("FAIL rnd_rsp: got unexpected response id=%0d want none", rsp_id);
        end else begin
          exp = exp_q.pop_front();
          if ({rsp_id, rsp_cout, rsp_s} !== exp) begin bad++; $display("FAIL rnd_rsp: got %h want %h", {rsp_id, rsp_cout, rsp_s}, exp); end
        end
        release_next = 1;
      end
      w = inflight ? -1 : model_pick(req_valid);
      exp_rdy = onehot(w);
      total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL rnd_grant: got %b want %b", req_ready, exp_rdy); end
      if (w >= 0) begin
        exp_q.push_back(model_result(w));
        model_last = w; inflight = 1; renew = w; accepts++;
      end
      @(negedge clk);
      cyc++;
    end
    total++; if (accepts < 40 || inflight || req_valid != '0) begin bad++; $display("FAIL rnd_timeout: got accepts=%0d want 40", accepts); end
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      op_a[i] = '0; op_b[i] = '0; op_cin[i] = 1'b0; op_op[i] = '0;
    end
    model_last = NREQ - 1;
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wrap_around();
    test_reset_mid_exec();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
